// File: rtl/sobel_buf_pkg.sv
// Shared types and constants for the Sobel window buffer and its address generator.
package sobel_buf_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SI_MODE_IDLE = 2'b00;
  localparam logic [1:0] SI_MODE_READ = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } state_e;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_buf_addr_gen.sv
// Walks the window slots row-major (full) or down the last column (slide)
// and produces the SRAM pixel address of the slot currently being fetched.
module sobel_buf_addr_gen
  import sobel_buf_pkg::*;
#(
  parameter int NUM_ROWS      = 3,
  parameter int WORDS_PER_ROW = 1,
  parameter int ADDR_W        = 20,
  parameter int WIDTH_W       = 12,
  localparam int SLOTS        = NUM_ROWS * WORDS_PER_ROW,
  localparam int SLOT_W       = idx_w(SLOTS)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic               advance,
  input  logic               slide_mode,
  input  logic [ADDR_W-1:0]  base,
  input  logic [WIDTH_W-1:0] image_width,
  output logic [ADDR_W-1:0]  addr,
  output logic [SLOT_W-1:0]  slot,
  output logic               last
);

  localparam int WORD_CW = idx_w(WORDS_PER_ROW);
  localparam logic [WORD_CW-1:0] WLAST = WORD_CW'(WORDS_PER_ROW - 1);

  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  row_off_q, row_off_d;
  logic [WORD_CW-1:0] word_q, word_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic               slide_q, slide_d;

  assign last = (slot_q == SLOT_W'(SLOTS - 1));
  assign slot = slot_q;
  assign addr = base_q + row_off_q + ADDR_W'({word_q, 2'b00});

  always_comb begin
    base_d    = base_q;
    row_off_d = row_off_q;
    word_d    = word_q;
    slot_d    = slot_q;
    slide_d   = slide_q;
    if (start) begin
      base_d    = base;
      row_off_d = '0;
      slide_d   = slide_mode;
      word_d    = slide_mode ? WLAST : '0;
      slot_d    = slide_mode ? SLOT_W'(WORDS_PER_ROW - 1) : '0;
    end else if (advance && !last) begin
      // In slide mode the word index is pinned to the last column, so every step is a row step.
      if (word_q == WLAST) begin
        word_d    = slide_q ? WLAST : '0;
        row_off_d = row_off_q + ADDR_W'(image_width);
      end else begin
        word_d = word_q + WORD_CW'(1);
      end
      slot_d = slot_q + (slide_q ? SLOT_W'(WORDS_PER_ROW) : SLOT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      base_q    <= '0;
      row_off_q <= '0;
      word_q    <= '0;
      slot_q    <= '0;
      slide_q   <= 1'b0;
    end else begin
      base_q    <= base_d;
      row_off_q <= row_off_d;
      word_q    <= word_d;
      slot_q    <= slot_d;
      slide_q   <= slide_d;
    end
  end

endmodule

// File: rtl/sobel_window_buffer.sv
// Fetches a NUM_ROWS x WORDS_PER_ROW word window from the SRAM interface,
// with full refill or one-word sliding refill, and presents it as a flat vector.
module sobel_window_buffer
  import sobel_buf_pkg::*;
#(
  parameter int NUM_ROWS      = 3,
  parameter int WORDS_PER_ROW = 1,
  parameter int ADDR_W        = 20,
  parameter int WIDTH_W       = 12
) (
  input  logic                                    clk,
  input  logic                                    n_rst,
  input  logic [WIDTH_W-1:0]                      image_width,
  input  logic                                    fill_buff,
  input  logic                                    slide,
  input  logic                                    clear,
  input  logic [ADDR_W-1:0]                       ED_rpixNum,
  input  logic                                    SI_dfb,
  input  logic [WORD_W-1:0]                       SI_rdata,
  output logic [ADDR_W-1:0]                       SI_rpixNum,
  output logic [1:0]                              SI_mode,
  output logic                                    buff_filled,
  output logic                                    busy,
  output logic [WORD_W*NUM_ROWS*WORDS_PER_ROW-1:0] ED_rdata
);

  localparam int SLOTS  = NUM_ROWS * WORDS_PER_ROW;
  localparam int SLOT_W = idx_w(SLOTS);

  state_e      state_q;
  logic        valid_q;
  logic        filled_q;
  logic        busy_q;
  logic [1:0]  mode_q;

  logic [WORD_W*SLOTS-1:0] window_q, window_d;

  logic              accept, slide_sel, capture, do_shift, gen_last;
  logic [SLOT_W-1:0] gen_slot;

  assign accept    = fill_buff && !clear && (state_q != FETCH);
  assign slide_sel = slide && valid_q;
  assign capture   = (state_q == FETCH) && SI_dfb && !clear;
  assign do_shift  = accept && slide_sel;

  sobel_buf_addr_gen #(
    .NUM_ROWS     (NUM_ROWS),
    .WORDS_PER_ROW(WORDS_PER_ROW),
    .ADDR_W       (ADDR_W),
    .WIDTH_W      (WIDTH_W)
  ) u_addr_gen (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (accept),
    .advance    (capture),
    .slide_mode (slide_sel),
    .base       (ED_rpixNum),
    .image_width(image_width),
    .addr       (SI_rpixNum),
    .slot       (gen_slot),
    .last       (gen_last)
  );

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      localparam int WORD = gi % WORDS_PER_ROW;
      logic [WORD_W-1:0] shifted;
      // The last word of each row has no right neighbour; it is refetched after the shift.
      if (WORD < WORDS_PER_ROW - 1) begin : g_nbr
        assign shifted = window_q[(gi+1)*WORD_W +: WORD_W];
      end else begin : g_keep
        assign shifted = window_q[gi*WORD_W +: WORD_W];
      end
      assign window_d[gi*WORD_W +: WORD_W] =
        (capture && (gen_slot == SLOT_W'(gi))) ? SI_rdata :
        do_shift                                ? shifted  :
                                                  window_q[gi*WORD_W +: WORD_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      window_q <= '0;
    end else begin
      window_q <= window_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      filled_q <= 1'b0;
      busy_q   <= 1'b0;
      mode_q   <= SI_MODE_IDLE;
    end else if (clear) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      filled_q <= 1'b0;
      busy_q   <= 1'b0;
      mode_q   <= SI_MODE_IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (fill_buff) begin
            state_q  <= FETCH;
            filled_q <= 1'b0;
            busy_q   <= 1'b1;
            mode_q   <= SI_MODE_READ;
          end
        end
        FETCH: begin
          if (SI_dfb && gen_last) begin
            state_q  <= DONE;
            valid_q  <= 1'b1;
            filled_q <= 1'b1;
            busy_q   <= 1'b0;
            mode_q   <= SI_MODE_IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SI_mode     = mode_q;
  assign busy        = busy_q;
  assign buff_filled = filled_q;
  assign ED_rdata    = window_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for sobel_window_buffer: one instance at default geometry, one at two words per row.
module tb_sobel_window_buffer;

  logic        clk;
  logic        n_rst;
  logic [11:0] image_width;
  logic        fill_a, fill_b, slide, clear, dfb;
  logic [19:0] base;

  logic [19:0]  rpix_a, rpix_b;
  logic [1:0]   mode_a, mode_b;
  logic         filled_a, filled_b, busy_a, busy_b;
  logic [95:0]  ed_a;
  logic [191:0] ed_b;
  logic [31:0]  rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  logic [31:0]  mdl [2][6];
  logic         mvalid [2];
  logic [19:0]  addr_q [$];
  logic [191:0] win_q [$];

  function automatic logic [31:0] pix_word(input logic [19:0] a);
    logic [7:0] p;
    p = a[7:0];
    return {p + 8'd3, p + 8'd2, p + 8'd1, p};
  endfunction

  assign rdata_a = pix_word(rpix_a);
  assign rdata_b = pix_word(rpix_b);

  sobel_window_buffer #(.NUM_ROWS(3), .WORDS_PER_ROW(1), .ADDR_W(20), .WIDTH_W(12)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .image_width(image_width), .fill_buff(fill_a), .slide(slide),
    .clear(clear), .ED_rpixNum(base), .SI_dfb(dfb), .SI_rdata(rdata_a), .SI_rpixNum(rpix_a),
    .SI_mode(mode_a), .buff_filled(filled_a), .busy(busy_a), .ED_rdata(ed_a));

  sobel_window_buffer #(.NUM_ROWS(3), .WORDS_PER_ROW(2), .ADDR_W(20), .WIDTH_W(12)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .image_width(image_width), .fill_buff(fill_b), .slide(slide),
    .clear(clear), .ED_rpixNum(base), .SI_dfb(dfb), .SI_rdata(rdata_b), .SI_rpixNum(rpix_b),
    .SI_mode(mode_b), .buff_filled(filled_b), .busy(busy_b), .ED_rdata(ed_b));

  wire [19:0]  o_rpix   = (cur == 1) ? rpix_b   : rpix_a;
  wire [1:0]   o_mode   = (cur == 1) ? mode_b   : mode_a;
  wire         o_filled = (cur == 1) ? filled_b : filled_a;
  wire         o_busy   = (cur == 1) ? busy_b   : busy_a;
  wire [191:0] o_win    = (cur == 1) ? ed_b     : {96'b0, ed_a};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [191:0] pack(input int sel);
    logic [191:0] v;
    int wpr;
    v = '0;
    wpr = (sel == 1) ? 2 : 1;
    for (int k = 0; k < 3 * wpr; k++) v[k*32 +: 32] = mdl[sel][k];
    return v;
  endfunction

  task automatic set_fill(input int sel, input logic v);
    if (sel == 1) fill_b = v; else fill_a = v;
  endtask

  task automatic run_fetch(input int sel, input logic [19:0] b, input logic sl,
                           input int waits, input logic inj);
    int wpr, n, edges, wc;
    logic do_sl, done, pop;
    logic [19:0] a;
    wpr = (sel == 1) ? 2 : 1;
    n = 0;
    do_sl = sl && mvalid[sel];
    if (do_sl)
      for (int r = 0; r < 3; r++)
        for (int w = 0; w < wpr - 1; w++) mdl[sel][r*wpr+w] = mdl[sel][r*wpr+w+1];
    for (int r = 0; r < 3; r++)
      for (int w = 0; w < wpr; w++)
        if (!do_sl || w == wpr - 1) begin
          a = b + r * image_width + 4 * w;
          addr_q.push_back(a);
          mdl[sel][r*wpr+w] = pix_word(a);
          n++;
        end
    win_q.push_back(pack(sel));
    mvalid[sel] = 1'b1;
    cur = sel;
    @(negedge clk);
    base = b; slide = sl; dfb = 1'b0;
    set_fill(sel, 1'b1);
    @(negedge clk);
    set_fill(sel, 1'b0);
    edges = 0; wc = 0; done = 1'b0;
    while (!done && edges < 200) begin
      if (o_filled) begin
        done = 1'b1;
      end else begin
        check("busy_fetch", o_busy, 1);
        check("mode_fetch", o_mode, 2'b01);
        if (addr_q.size() == 0) check("extra_read", 1, 0);
        else check("rd_addr", o_rpix, addr_q[0]);
        if (inj && edges == 1) begin
          set_fill(sel, 1'b1); base = b + 20'h40;
        end else begin
          set_fill(sel, 1'b0); base = b;
        end
        if (wc < waits) begin dfb = 1'b0; wc++; pop = 1'b0; end
        else begin dfb = 1'b1; wc = 0; pop = 1'b1; end
        @(negedge clk);
        edges++;
        if (pop && addr_q.size() != 0) void'(addr_q.pop_front());
      end
    end
    set_fill(sel, 1'b0); dfb = 1'b0;
    check("fill_timeout", done, 1);
    check("fill_latency", edges, n * (waits + 1));
    check("window", o_win, win_q.pop_front());
    check("mode_done", o_mode, 2'b00);
    check("busy_done", o_busy, 0);
    check("reads_left", addr_q.size(), 0);
    $display("fetch dut=%0d base=%h slide=%0d waits=%0d reads=%0d edges=%0d win=%h",
             sel, b, do_sl, waits, n, edges, o_win);
  endtask

  task automatic run_clear(input logic [19:0] b);
    cur = 0;
    @(negedge clk);
    base = b; slide = 1'b0; dfb = 1'b0; fill_a = 1'b1;
    @(negedge clk);
    fill_a = 1'b0; dfb = 1'b1;
    check("clr_addr0", o_rpix, b);
    @(negedge clk);
    check("clr_addr1", o_rpix, b + 20'(image_width));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; dfb = 1'b0;
    check("clr_busy", o_busy, 0);
    check("clr_mode", o_mode, 2'b00);
    check("clr_filled", o_filled, 0);
    mdl[0][0] = pix_word(b);
    mvalid[0] = 1'b0;
    check("clr_window_kept", o_win, pack(0));
    repeat (3) @(negedge clk);
    check("clr_filled_stays", o_filled, 0);
    $display("clear dut=0 base=%h win=%h", b, o_win);
  endtask

  task automatic run_reset_mid_fetch();
    cur = 0;
    @(negedge clk);
    base = 20'h0010; slide = 1'b0; dfb = 1'b0; fill_a = 1'b1;
    @(negedge clk);
    fill_a = 1'b0;
    check("rst_pre_busy", o_busy, 1);
    #2 n_rst = 1'b0;
    #1;
    check("rst_mode", o_mode, 2'b00);
    check("rst_addr", o_rpix, 0);
    check("rst_busy", o_busy, 0);
    check("rst_filled", o_filled, 0);
    check("rst_win_a", o_win, 0);
    check("rst_filled_b", filled_b, 0);
    check("rst_win_b", ed_b, 0);
    $display("async reset mid-fetch: mode=%0d busy=%0d filled=%0d", o_mode, o_busy, o_filled);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    logic [95:0] tp_win;
    n_rst = 1'b0; image_width = 12'd8; fill_a = 1'b0; fill_b = 1'b0;
    slide = 1'b0; clear = 1'b0; dfb = 1'b0; base = '0;
    for (int s = 0; s < 2; s++) begin
      mvalid[s] = 1'b0;
      for (int k = 0; k < 6; k++) mdl[s][k] = '0;
    end
    #3;
    check("reset_mode_a", mode_a, 2'b00);
    check("reset_addr_a", rpix_a, 0);
    check("reset_busy_a", busy_a, 0);
    check("reset_filled_a", filled_a, 0);
    check("reset_win_a", ed_a, 0);
    check("reset_win_b", ed_b, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_mode_a", mode_a, 2'b00);
    check("idle_mode_b", mode_b, 2'b00);
    check("idle_busy_b", busy_b, 0);
    $display("reset and idle checked");

    image_width = 12'd8;
    run_fetch(0, 20'h00000, 1'b0, 0, 1'b0);
    tp_win = 96'h13121110_0B0A0908_03020100;
    check("known_window", ed_a, tp_win);
    run_fetch(0, 20'h00000, 1'b0, 2, 1'b0);
    check("known_window_waits", ed_a, tp_win);
    run_fetch(0, 20'hFFFFC, 1'b0, 1, 1'b0);

    image_width = 12'd16;
    run_fetch(1, 20'h00004, 1'b0, 0, 1'b0);
    run_fetch(1, 20'h00008, 1'b1, 0, 1'b0);
    run_fetch(1, 20'h0000C, 1'b1, 1, 1'b0);

    image_width = 12'd8;
    run_clear(20'h00100);
    run_fetch(0, 20'h00100, 1'b1, 0, 1'b1);

    run_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
